// File: rtl/sw_max_score_collector.sv
// Collects the final Smith-Waterman PE row's score stream and reports the
// maximum score plus the reference column of its first occurrence.
module sw_max_score_collector #(
    parameter int SCORE_WIDTH = 10,
    parameter int POS_WIDTH   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [POS_WIDTH-1:0]   i_ref_len,
    input  logic [SCORE_WIDTH-1:0] i_v_in,
    input  logic                   i_init_in,
    output logic                   o_busy,
    output logic                   o_result_valid,
    input  logic                   i_result_ready,
    output logic [SCORE_WIDTH-1:0] o_max_score,
    output logic [POS_WIDTH-1:0]   o_max_pos,
    output logic                   o_drop_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [POS_WIDTH-1:0]   r_len;
    logic [POS_WIDTH-1:0]   r_count;
    logic [SCORE_WIDTH-1:0] r_max_score;
    logic [POS_WIDTH-1:0]   r_max_pos;
    logic                   r_drop_err;

    logic w_restart;
    logic w_take;
    logic w_last;
    logic w_better;

    // A start restarts from IDLE or COLLECT; DONE must be drained first.
    assign w_restart = i_start && ((r_state == IDLE) || (r_state == COLLECT));
    assign w_take    = (r_state == COLLECT) && i_init_in && !i_start;
    assign w_last    = (r_count == (r_len - POS_WIDTH'(1)));
    assign w_better  = $signed(i_v_in) > $signed(r_max_score);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = (i_ref_len != '0) ? COLLECT : DONE;
                end
            end
            COLLECT: begin
                if (i_start) begin
                    w_next_state = (i_ref_len != '0) ? COLLECT : DONE;
                end else if (i_init_in && w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (o_result_valid && i_result_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_max_score <= '0;
            r_max_pos   <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_restart) begin
                r_len       <= i_ref_len;
                r_count     <= '0;
                r_max_score <= '0;
                r_max_pos   <= '0;
                r_drop_err  <= 1'b0;
            end else begin
                if (w_take) begin
                    r_count <= r_count + POS_WIDTH'(1);
                    // Strict compare so ties keep the earliest column.
                    if (w_better) begin
                        r_max_score <= i_v_in;
                        r_max_pos   <= r_count;
                    end
                end
                if (i_init_in && (r_state != COLLECT)) begin
                    r_drop_err <= 1'b1;
                end
            end
        end
    end

    assign o_busy         = (r_state == COLLECT);
    assign o_result_valid = (r_state == DONE);
    assign o_max_score    = r_max_score;
    assign o_max_pos      = r_max_pos;
    assign o_drop_err     = r_drop_err;

endmodule

// File: tb/tb_sw_max_score_collector.sv
// Directed self-checking bench for sw_max_score_collector with hand-computed
// expected results for each alignment scenario.
module tb_sw_max_score_collector;

    localparam int SW = 10;
    localparam int PW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [PW-1:0] refLen;
    logic [SW-1:0] vIn;
    logic          initIn;
    logic          busy;
    logic          resultValid;
    logic          resultReady;
    logic [SW-1:0] maxScore;
    logic [PW-1:0] maxPos;
    logic          dropErr;

    int checkCount = 0;
    int errorCount = 0;

    sw_max_score_collector #(.SCORE_WIDTH(SW), .POS_WIDTH(PW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_ref_len      (refLen),
        .i_v_in         (vIn),
        .i_init_in      (initIn),
        .o_busy         (busy),
        .o_result_valid (resultValid),
        .i_result_ready (resultReady),
        .o_max_score    (maxScore),
        .o_max_pos      (maxPos),
        .o_drop_err     (dropErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Inputs change #1 after a rising edge so outputs are read away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input int len, input logic init, input int v);
        start  = s;
        refLen = PW'(len);
        initIn = init;
        vIn    = SW'(v);
        tick();
        start  = 1'b0;
        initIn = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic v, input logic b,
                               input int score, input int pos);
        checkOutput({tag, "_valid"}, 32'(resultValid), 32'(v));
        checkOutput({tag, "_busy"},  32'(busy),        32'(b));
        checkOutput({tag, "_score"}, 32'(maxScore),    32'(score));
        checkOutput({tag, "_pos"},   32'(maxPos),      32'(pos));
    endtask

    int s1[8] = '{10, 8, 10, 8, 10, 8, 7, 10};
    int s2[8] = '{8, 8, 8, 8, 8, 8, 20, 18};

    initial begin
        rst = 1'b0; start = 1'b0; refLen = '0; vIn = '0; initIn = 1'b0; resultReady = 1'b1;
        tick(); tick();
        checkResult("reset", 1'b0, 1'b0, 0, 0);
        checkOutput("reset_drop", 32'(dropErr), 0);
        rst = 1'b1;

        // Scenario 1: back-to-back samples, ties keep first column.
        applyStimulus(1'b1, 8, 1'b0, 0);
        checkOutput("s1_busy", 32'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) checkOutput("s1_noearly", 32'(resultValid), 0);
            applyStimulus(1'b0, 0, 1'b1, s1[i]);
        end
        checkResult("s1_done", 1'b1, 1'b0, 10, 0);
        tick();
        checkResult("s1_idle", 1'b0, 1'b0, 10, 0);

        // Scenario 2: gapped samples.
        applyStimulus(1'b1, 8, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 0, 1'b1, s2[i]);
            if (i < 7) begin
                checkOutput("s2_busy_a", 32'(busy), 1);
                checkOutput("s2_early_a", 32'(resultValid), 0);
                applyStimulus(1'b0, 0, 1'b0, 99);
                checkOutput("s2_busy_b", 32'(busy), 1);
                checkOutput("s2_early_b", 32'(resultValid), 0);
            end
        end
        checkResult("s2_done", 1'b1, 1'b0, 20, 6);
        tick();

        // Scenario 3: backpressure with ignored starts.
        resultReady = 1'b0;
        applyStimulus(1'b1, 8, 1'b0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 0, 1'b1, s1[i]);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5, 1'b0, 0);
            checkResult("s3_hold", 1'b1, 1'b0, 10, 0);
        end
        resultReady = 1'b1;
        tick();
        checkResult("s3_release", 1'b0, 1'b0, 10, 0);

        // Scenario 4: zero length, drop errors, negative sample.
        applyStimulus(1'b1, 0, 1'b0, 0);
        checkResult("s4_zero", 1'b1, 1'b0, 0, 0);
        tick();
        checkOutput("s4_idle", 32'(resultValid), 0);
        applyStimulus(1'b0, 0, 1'b1, 3);
        checkOutput("s4_drop_idle", 32'(dropErr), 1);
        applyStimulus(1'b1, 1, 1'b0, 0);
        checkOutput("s4_drop_clr", 32'(dropErr), 0);
        checkOutput("s4_busy", 32'(busy), 1);
        resultReady = 1'b0;
        applyStimulus(1'b0, 0, 1'b1, -5);
        checkResult("s4_neg", 1'b1, 1'b0, 0, 0);
        applyStimulus(1'b0, 0, 1'b1, 7);
        checkOutput("s4_drop_done", 32'(dropErr), 1);
        checkOutput("s4_done_score", 32'(maxScore), 0);
        resultReady = 1'b1;
        tick();

        // Scenario 5: restart mid-collect; coincident samples ignored.
        applyStimulus(1'b1, 8, 1'b1, 100);
        checkOutput("s5_nodrop", 32'(dropErr), 0);
        applyStimulus(1'b0, 0, 1'b1, 5);
        applyStimulus(1'b0, 0, 1'b1, 9);
        applyStimulus(1'b0, 0, 1'b1, 2);
        checkOutput("s5_mid", 32'(maxScore), 9);
        applyStimulus(1'b1, 2, 1'b1, 50);
        checkResult("s5_restart", 1'b0, 1'b1, 0, 0);
        applyStimulus(1'b0, 0, 1'b1, 3);
        applyStimulus(1'b0, 0, 1'b1, 4);
        checkResult("s5_done", 1'b1, 1'b0, 4, 1);
        checkOutput("s5_drop", 32'(dropErr), 0);
        tick();

        // Scenario 6: reset mid-collect and mid-done, then a full-range run.
        applyStimulus(1'b1, 8, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 6);
        applyStimulus(1'b0, 0, 1'b1, 8);
        rst = 1'b0;
        tick();
        checkResult("s6_rst_col", 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        resultReady = 1'b0;
        applyStimulus(1'b1, 1, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 7);
        checkResult("s6_pre", 1'b1, 1'b0, 7, 0);
        applyStimulus(1'b0, 0, 1'b1, 1);
        checkOutput("s6_pre_drop", 32'(dropErr), 1);
        rst = 1'b0;
        tick();
        checkResult("s6_rst_done", 1'b0, 1'b0, 0, 0);
        checkOutput("s6_rst_drop", 32'(dropErr), 0);
        rst = 1'b1;
        resultReady = 1'b1;
        applyStimulus(1'b1, 3, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 3);
        applyStimulus(1'b0, 0, 1'b1, -512);
        applyStimulus(1'b0, 0, 1'b1, 511);
        checkResult("s6_after", 1'b1, 1'b0, 511, 2);
        tick();
        checkOutput("s6_idle", 32'(resultValid), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
